reg_shift_univ: RTL and testbench
=================================

// Module: reg_shift_univ
// PURPOSE
//  Parametrised universal shift register: next generation of the 4-bit serial-in/serial-out chain.
//  Supports hold, shift right, shift left and parallel load at any WIDTH.
//  Adds an autonomous burst mode that shifts a programmed number of bits, then pulses done.
//  Serves as the common serialiser/deserialiser primitive for the training datapath blocks.
// PARAMETERS
//  WIDTH  4                  register width in bits (>=2)
//  CNT_W  $clog2(WIDTH+1)    width of burst_len and the internal burst counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  reset      in   1      synchronous, active-low; sampled only on posedge clk
//  en         in   1      global clock enable; 0 = freeze all state, including the burst FSM
//  mode       in   2      00 HOLD, 01 SHR, 10 SHL, 11 LOAD (used when idle)
//  ser_in     in   1      serial input bit, used by SHR and SHL
//  pdin       in   WIDTH  parallel load data
//  start      in   1      request a burst; sampled only when idle and en=1
//  burst_len  in   CNT_W  number of shifts in the burst; latched on start
//  q          out  WIDTH  register contents (parallel out)
//  so_r       out  1      q[0]; serial out of SHR
//  so_l       out  1      q[WIDTH-1]; serial out of SHL
//  busy       out  1      1 while the FSM is in SHIFT
//  done       out  1      one-cycle pulse when a burst completes
// BEHAVIOUR
//  - Reset (reset=0 at posedge): q=0, busy=0, done=0, FSM=IDLE, counter=0, latched dir=0.
//  - Reset overrides en and aborts any burst in progress, with no done pulse.
//  - en=0: q, FSM, counter and latched dir hold; done is forced to 0 and busy holds.
//  - IDLE, en=1, start=0: mode applies with 1-cycle latency (q is visible the cycle after the edge).
//      HOLD: q <= q
//      SHR:  q <= {ser_in, q[WIDTH-1:1]}
//      SHL:  q <= {q[WIDTH-2:0], ser_in}
//      LOAD: q <= pdin
//  - IDLE, en=1, start=1, mode in {SHR,SHL}, burst_len>0:
//      latch dir=mode and cnt=burst_len; enter SHIFT; q is not modified on this edge.
//  - IDLE, start=1, mode in {SHR,SHL}, burst_len=0:
//      q unchanged; done=1 on the next cycle; FSM stays IDLE.
//  - IDLE, start=1, mode in {HOLD,LOAD}: start is ignored and mode executes normally.
//  - SHIFT, en=1: one shift per cycle in the latched dir using the live ser_in; cnt <= cnt-1.
//      On the edge where cnt==1: perform the last shift, go to IDLE, done=1 for the next cycle.
//      mode, pdin, start and burst_len are ignored while busy.
//  - Burst timing: start edge, then exactly burst_len shifting edges.
//      busy is high for burst_len cycles; done follows the last shift edge.
//  - done is a registered 1-cycle pulse and is 0 in all other cycles.
//      A new start is accepted in the same cycle done is high, since the FSM is already IDLE.
//  - Counter arithmetic is unsigned CNT_W bits and never wraps (no decrement at 0).
//      burst_len > WIDTH is legal; the register continues to shift in ser_in.
//  - so_r and so_l are combinational from q, so they share q's reset value of 0.
// STRUCTURE
//  - Shared include reg_shift_defs.vh: `define MODE_HOLD 2'b00, MODE_SHR 2'b01,
//    MODE_SHL 2'b10, MODE_LOAD 2'b11, ST_IDLE 1'b0, ST_SHIFT 1'b1.
//  - Sub-module reg_shift_core: WIDTH flops with next-state mux (ctrl, ser_in, pdin, en, reset).
//  - Top level holds the IDLE/SHIFT FSM, burst counter, latched dir and done register,
//    and drives the core's ctrl input.
// TESTING (WIDTH=4)
//  1. reset=0 for 2 cycles with en=1, mode=LOAD, pdin=4'hF
//       -> q=0, busy=0, done=0 throughout.
//  2. LOAD pdin=4'b1010, then SHR with ser_in=1 for 2 cycles
//       -> q=1010, then 1101, then 1110; so_r=0.
//  3. q=4'b0001, SHL with ser_in=0 for 3 cycles
//       -> q=0010, then 0100, then 1000; so_l=1.
//  4. q=4'b1011, start with mode=SHR, burst_len=3, ser_in=0
//       -> busy high 3 cycles, q=0101, 0010, 0001; done pulses once; mode toggled mid-burst is ignored.
//  5. Burst of len 4 with en=0 for 2 cycles mid-burst
//       -> shifts pause with busy held; 4 shifts total; done pulses once.
//     Then start with burst_len=0 -> q unchanged, done next cycle, busy stays 0.
//  6. reset=0 asserted during the 2nd shift of a burst_len=4 burst
//       -> q=0, busy=0, no done pulse.
//     Then start with mode=LOAD -> start ignored and q=pdin.

Source files
------------

// File: rtl/reg_shift_univ_pkg.sv
// Shared mode and FSM state encodings for the universal shift register.
// The encodings match the original MODE_*/ST_* define values.
package reg_shift_univ_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/reg_shift_core.sv
// WIDTH-bit register with a hold/shift-right/shift-left/load next-state mux.
// It is gated by en and cleared by a synchronous active-low reset.
module reg_shift_core
    import reg_shift_univ_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  mode_e            ctrl,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            case (ctrl)
                MODE_HOLD: q <= q;
                MODE_SHR:  q <= {ser_in, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], ser_in};
                MODE_LOAD: q <= pdin;
            endcase
        end
    end

endmodule

// File: rtl/reg_shift_univ.sv
// Universal shift register top. It contains the IDLE/SHIFT burst FSM, the burst
// counter, the latched direction and the done pulse register around reg_shift_core.
module reg_shift_univ
    import reg_shift_univ_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] pdin,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    mode_e            dir, dir_next, core_ctrl;
    logic             done_next;
    logic             is_shift_mode;

    assign is_shift_mode = (mode == MODE_SHR) || (mode == MODE_SHL);

    // A zero-length burst only produces done. The register holds on the start edge of every burst.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir;
        done_next  = 1'b0;
        core_ctrl  = MODE_HOLD;
        case (state)
            ST_IDLE: begin
                if (start && is_shift_mode) begin
                    if (burst_len != '0) begin
                        state_next = ST_SHIFT;
                        cnt_next   = burst_len;
                        dir_next   = mode_e'(mode);
                    end else begin
                        done_next = 1'b1;
                    end
                end else begin
                    core_ctrl = mode_e'(mode);
                end
            end
            ST_SHIFT: begin
                core_ctrl = dir;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end
                if (cnt <= CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            dir   <= MODE_HOLD;
            done  <= 1'b0;
        end else if (en) begin
            state <= state_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
            done  <= done_next;
        end else begin
            done  <= 1'b0;
        end
    end

    reg_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .ctrl   (core_ctrl),
        .ser_in (ser_in),
        .pdin   (pdin),
        .q      (q)
    );

    assign busy = (state == ST_SHIFT);
    assign so_r = q[0];
    assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_reg_shift_univ.sv
// Self-checking bench for reg_shift_univ (WIDTH=4). It combines directed scenarios
// with literal expectations and a randomized run checked every cycle against a behavioural model.
module tb_reg_shift_univ;
    import reg_shift_univ_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] pdin;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             so_r, so_l, busy, done;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // The model describes behaviour: the bits still to shift, the direction, and whether a pulse is owed.
    logic [WIDTH-1:0] m_q;
    bit               m_busy;
    int               m_rem;
    logic [1:0]       m_dir;
    bit               m_done;

    always #5 clk = ~clk;

    reg_shift_univ #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .ser_in    (ser_in),
        .pdin      (pdin),
        .start     (start),
        .burst_len (burst_len),
        .q         (q),
        .so_r      (so_r),
        .so_l      (so_l),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input logic [1:0] d,
                                                 input logic s);
        if (d == MODE_SHR)
            return WIDTH'((int'(v) >> 1) + (int'(s) << (WIDTH - 1)));
        else
            return WIDTH'((int'(v) << 1) + int'(s));
    endfunction

    // This task advances one clock edge. The model takes its next state from the inputs held across that edge.
    task automatic apply_stimulus();
        logic [WIDTH-1:0] nq;
        bit nb, nd;
        int nr;
        logic [1:0] ndir;
        nq = m_q; nb = m_busy; nr = m_rem; ndir = m_dir; nd = 1'b0;
        if (!reset) begin
            nq = '0; nb = 1'b0; nr = 0; ndir = 2'b00;
        end else if (en) begin
            if (m_busy) begin
                nq = shifted(m_q, m_dir, ser_in);
                nr = m_rem - 1;
                if (nr == 0) begin nb = 1'b0; nd = 1'b1; end
            end else if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
                if (burst_len > 0) begin nb = 1'b1; nr = int'(burst_len); ndir = mode; end
                else nd = 1'b1;
            end else if (mode == MODE_LOAD) begin
                nq = pdin;
            end else if (mode != MODE_HOLD) begin
                nq = shifted(m_q, mode, ser_in);
            end
        end
        @(posedge clk);
        m_q = nq; m_busy = nb; m_rem = nr; m_dir = ndir; m_done = nd;
        check_en = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("q", 32'(q), 32'(m_q));
            check_output("so_r", 32'(so_r), 32'(m_q[0]));
            check_output("so_l", 32'(so_l), 32'(m_q[WIDTH-1]));
            check_output("busy", 32'(busy), 32'(m_busy));
            check_output("done", 32'(done), 32'(m_done));
        end
    end

    task automatic idle_op(input logic [1:0] md, input logic s, input logic [WIDTH-1:0] d);
        mode = md; ser_in = s; pdin = d; start = 1'b0;
        apply_stimulus();
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; mode = MODE_LOAD; pdin = 4'hF;
        ser_in = 1'b0; start = 1'b0; burst_len = '0;

        // Test 1: reset has priority over a pending load.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus();
            check_output("t1_q", 32'(q), 32'h0);
            check_output("t1_busy", 32'(busy), 32'h0);
            check_output("t1_done", 32'(done), 32'h0);
        end
        reset = 1'b1;

        // Test 2
        idle_op(MODE_LOAD, 1'b0, 4'b1010);
        check_output("t2_load", 32'(q), 32'b1010);
        idle_op(MODE_SHR, 1'b1, 4'h0);
        check_output("t2_shr1", 32'(q), 32'b1101);
        idle_op(MODE_SHR, 1'b1, 4'h0);
        check_output("t2_shr2", 32'(q), 32'b1110);
        check_output("t2_so_r", 32'(so_r), 32'h0);

        // Test 3
        idle_op(MODE_LOAD, 1'b0, 4'b0001);
        idle_op(MODE_SHL, 1'b0, 4'h0);
        check_output("t3_shl1", 32'(q), 32'b0010);
        idle_op(MODE_SHL, 1'b0, 4'h0);
        check_output("t3_shl2", 32'(q), 32'b0100);
        idle_op(MODE_SHL, 1'b0, 4'h0);
        check_output("t3_shl3", 32'(q), 32'b1000);
        check_output("t3_so_l", 32'(so_l), 32'h1);

        // Test 4: a 3-bit right burst while mode and pdin are changed mid-burst.
        idle_op(MODE_LOAD, 1'b0, 4'b1011);
        mode = MODE_SHR; ser_in = 1'b0; start = 1'b1; burst_len = 3'd3;
        apply_stimulus();
        check_output("t4_busy0", 32'(busy), 32'h1);
        check_output("t4_q0", 32'(q), 32'b1011);
        start = 1'b0; mode = MODE_LOAD; pdin = 4'hF;
        apply_stimulus();
        check_output("t4_q1", 32'(q), 32'b0101);
        mode = MODE_SHL;
        apply_stimulus();
        check_output("t4_q2", 32'(q), 32'b0010);
        apply_stimulus();
        check_output("t4_q3", 32'(q), 32'b0001);
        check_output("t4_busy3", 32'(busy), 32'h0);
        check_output("t4_done", 32'(done), 32'h1);
        idle_op(MODE_HOLD, 1'b0, 4'h0);
        check_output("t4_done_off", 32'(done), 32'h0);

        // Test 5: a 4-bit left burst that pauses for two en=0 cycles, then a zero-length burst.
        idle_op(MODE_LOAD, 1'b0, 4'b0110);
        mode = MODE_SHL; ser_in = 1'b1; start = 1'b1; burst_len = 3'd4;
        apply_stimulus();
        start = 1'b0;
        apply_stimulus();
        check_output("t5_q1", 32'(q), 32'b1101);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus();
            check_output("t5_pause_q", 32'(q), 32'b1101);
            check_output("t5_pause_busy", 32'(busy), 32'h1);
        end
        en = 1'b1;
        apply_stimulus();
        apply_stimulus();
        check_output("t5_busy_pre", 32'(busy), 32'h1);
        check_output("t5_done_pre", 32'(done), 32'h0);
        apply_stimulus();
        check_output("t5_q4", 32'(q), 32'b1111);
        check_output("t5_done", 32'(done), 32'h1);
        mode = MODE_SHR; ser_in = 1'b0; start = 1'b1; burst_len = 3'd0;
        apply_stimulus();
        check_output("t5_zero_q", 32'(q), 32'b1111);
        check_output("t5_zero_done", 32'(done), 32'h1);
        check_output("t5_zero_busy", 32'(busy), 32'h0);
        idle_op(MODE_HOLD, 1'b0, 4'h0);
        check_output("t5_zero_done_off", 32'(done), 32'h0);

        // Test 6: reset during the second shift of a burst, then start with mode=LOAD.
        idle_op(MODE_LOAD, 1'b0, 4'b1001);
        mode = MODE_SHR; ser_in = 1'b0; start = 1'b1; burst_len = 3'd4;
        apply_stimulus();
        start = 1'b0;
        apply_stimulus();
        check_output("t6_q1", 32'(q), 32'b0100);
        reset = 1'b0;
        apply_stimulus();
        check_output("t6_rst_q", 32'(q), 32'h0);
        check_output("t6_rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        idle_op(MODE_HOLD, 1'b0, 4'h0);
        check_output("t6_no_done", 32'(done), 32'h0);
        mode = MODE_LOAD; pdin = 4'b1010; start = 1'b1; burst_len = 3'd2;
        apply_stimulus();
        check_output("t6_load_q", 32'(q), 32'b1010);
        check_output("t6_load_busy", 32'(busy), 32'h0);
        start = 1'b0;

        // Randomized traffic checked against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 79) != 0);
            en        = ($urandom_range(0, 4) != 0);
            mode      = 2'($urandom_range(0, 3));
            ser_in    = 1'($urandom_range(0, 1));
            pdin      = WIDTH'($urandom);
            start     = ($urandom_range(0, 2) == 0);
            burst_len = CNT_W'($urandom);
            apply_stimulus();
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
